// File: rtl/execute_lane_mc.sv
// Execute lane: single-cycle ALU, pipelined multiplier and iterative restoring divider sharing one
// issue slot and one registered writeback port; a writeback-slot reservation vector prevents collisions.
module execute_lane_mc #(
    parameter int DATA_W     = 32,
    parameter int PREG_W     = 7,
    parameter int AL_W       = 7,
    parameter int NUM_BYPASS = 4,
    parameter int MUL_DEPTH  = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         recoverFlag_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic                         isSimple_i,
    input  logic [2:0]                   op_i,
    input  logic [PREG_W-1:0]            phySrc1_i,
    input  logic [PREG_W-1:0]            phySrc2_i,
    input  logic [DATA_W-1:0]            src1Data_i,
    input  logic [DATA_W-1:0]            src2Data_i,
    input  logic [PREG_W-1:0]            phyDest_i,
    input  logic [AL_W-1:0]              alID_i,
    input  logic [NUM_BYPASS-1:0]        bypValid_i,
    input  logic [NUM_BYPASS*PREG_W-1:0] bypTag_i,
    input  logic [NUM_BYPASS*DATA_W-1:0] bypData_i,
    output logic                         wbValid_o,
    output logic [PREG_W-1:0]            wbPhyDest_o,
    output logic [AL_W-1:0]              wbAlID_o,
    output logic [DATA_W-1:0]            wbData_o,
    output logic                         divBusy_o
);
    // state | meaning
    // IDLE  | divider free, may accept a div-class op
    // RUN   | one restoring iteration per cycle, r_cnt counts down to 0
    // DONE  | sign fix-up, result loaded into the writeback register
    localparam int DIV_LAT = DATA_W + 2;
    localparam int SH_W    = $clog2(DATA_W);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} div_state_t;
    div_state_t r_state, w_state_next;

    logic [DATA_W-1:0]    w_a, w_b, w_alu, w_simple_res, w_mul_res, w_q, w_r, w_div_res;
    logic [2*DATA_W-1:0]  w_prod;
    logic                 w_is_mul, w_is_div, w_slot_busy, w_accept, w_div_go;
    logic                 w_a_neg, w_b_neg;
    logic [DIV_LAT:1]     w_resv_next;
    logic [DIV_LAT:2]     r_resv, w_resv_set;

    logic [MUL_DEPTH-1:1] r_mul_vld;
    logic [DATA_W-1:0]    r_mul_data [1:MUL_DEPTH-1];
    logic [PREG_W-1:0]    r_mul_tag  [1:MUL_DEPTH-1];
    logic [AL_W-1:0]      r_mul_al   [1:MUL_DEPTH-1];

    logic [DATA_W-1:0]    r_quo, r_rem, r_dvsr, r_dvnd;
    logic [DATA_W:0]      w_rem_sh, w_diff;
    logic [SH_W-1:0]      r_cnt;
    logic                 r_neg_q, r_neg_r, r_is_rem, r_b_zero;
    logic [PREG_W-1:0]    r_div_tag;
    logic [AL_W-1:0]      r_div_al;

    // Walk channels high to low so the lowest matching index is the last writer.
    always_comb begin
        w_a = src1Data_i;
        w_b = src2Data_i;
        for (int i = NUM_BYPASS-1; i >= 0; i--) begin
            if (bypValid_i[i] && bypTag_i[i*PREG_W +: PREG_W] == phySrc1_i)
                w_a = bypData_i[i*DATA_W +: DATA_W];
            if (bypValid_i[i] && bypTag_i[i*PREG_W +: PREG_W] == phySrc2_i)
                w_b = bypData_i[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        w_is_mul    = !isSimple_i && (op_i <= 3'd1);
        w_is_div    = !isSimple_i && (op_i >= 3'd2) && (op_i <= 3'd5);
        w_resv_next = {1'b0, r_resv};
        w_slot_busy = w_is_div ? w_resv_next[DIV_LAT] :
                      w_is_mul ? w_resv_next[MUL_DEPTH] : w_resv_next[1];
        ready_o     = reset && !recoverFlag_i && !w_slot_busy && !(w_is_div && divBusy_o);
        w_accept    = valid_i && ready_o;
        w_div_go    = w_accept && w_is_div;
        w_resv_set  = '0;
        if (w_accept && w_is_div) w_resv_set[DIV_LAT]   = 1'b1;
        if (w_accept && w_is_mul) w_resv_set[MUL_DEPTH] = 1'b1;
    end

    always_comb begin
        w_alu = '0;
        unique case (op_i)
            3'd0: w_alu = w_a + w_b;
            3'd1: w_alu = w_a - w_b;
            3'd2: w_alu = w_a & w_b;
            3'd3: w_alu = w_a | w_b;
            3'd4: w_alu = w_a ^ w_b;
            3'd5: w_alu = {{(DATA_W-1){1'b0}}, $signed(w_a) < $signed(w_b)};
            3'd6: w_alu = {{(DATA_W-1){1'b0}}, w_a < w_b};
            3'd7: w_alu = w_a << w_b[SH_W-1:0];
            default: w_alu = '0;
        endcase
        w_simple_res = isSimple_i ? w_alu : '0;
        w_prod       = {{DATA_W{1'b0}}, w_a} * {{DATA_W{1'b0}}, w_b};
        w_mul_res    = op_i[0] ? w_prod[2*DATA_W-1:DATA_W] : w_prod[DATA_W-1:0];
        w_a_neg      = !op_i[0] && w_a[DATA_W-1];
        w_b_neg      = !op_i[0] && w_b[DATA_W-1];
    end

    always_comb begin
        w_rem_sh  = {r_rem, r_quo[DATA_W-1]};
        w_diff    = w_rem_sh - {1'b0, r_dvsr};
        w_q       = r_neg_q ? -r_quo : r_quo;
        w_r       = r_neg_r ? -r_rem : r_rem;
        if (r_b_zero) begin
            w_q = '1;
            w_r = r_dvnd;
        end
        w_div_res = r_is_rem ? w_r : w_q;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_div_go) w_state_next = S_RUN;
            S_RUN:   if (r_cnt == '0) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset || recoverFlag_i) begin
            r_state   <= S_IDLE;
            r_resv    <= '0;
            r_mul_vld <= '0;
        end else begin
            r_state   <= w_state_next;
            r_resv    <= w_resv_next[DIV_LAT:2] | w_resv_set;
            r_mul_vld <= {r_mul_vld, w_accept && w_is_mul};
        end
    end

    assign divBusy_o = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        r_mul_data[1] <= w_mul_res;
        r_mul_tag[1]  <= phyDest_i;
        r_mul_al[1]   <= alID_i;
        for (int k = 2; k < MUL_DEPTH; k++) begin
            r_mul_data[k] <= r_mul_data[k-1];
            r_mul_tag[k]  <= r_mul_tag[k-1];
            r_mul_al[k]   <= r_mul_al[k-1];
        end
    end

    // Divider works on magnitudes; signs are reapplied in DONE.
    always_ff @(posedge clk) begin
        if (w_div_go) begin
            r_quo     <= w_a_neg ? -w_a : w_a;
            r_dvsr    <= w_b_neg ? -w_b : w_b;
            r_rem     <= '0;
            r_dvnd    <= w_a;
            r_cnt     <= SH_W'(DATA_W-1);
            r_neg_q   <= w_a_neg ^ w_b_neg;
            r_neg_r   <= w_a_neg;
            r_is_rem  <= op_i[2];
            r_b_zero  <= (w_b == '0);
            r_div_tag <= phyDest_i;
            r_div_al  <= alID_i;
        end else if (r_state == S_RUN) begin
            r_quo <= {r_quo[DATA_W-2:0], !w_diff[DATA_W]};
            r_rem <= w_diff[DATA_W] ? w_rem_sh[DATA_W-1:0] : w_diff[DATA_W-1:0];
            r_cnt <= r_cnt - SH_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wbValid_o   <= 1'b0;
            wbPhyDest_o <= '0;
            wbAlID_o    <= '0;
            wbData_o    <= '0;
        end else if (recoverFlag_i) begin
            wbValid_o <= 1'b0;
        end else begin
            wbValid_o <= 1'b0;
            if (w_accept && !w_is_mul && !w_is_div) begin
                wbValid_o   <= 1'b1;
                wbPhyDest_o <= phyDest_i;
                wbAlID_o    <= alID_i;
                wbData_o    <= w_simple_res;
            end else if (r_mul_vld[MUL_DEPTH-1]) begin
                wbValid_o   <= 1'b1;
                wbPhyDest_o <= r_mul_tag[MUL_DEPTH-1];
                wbAlID_o    <= r_mul_al[MUL_DEPTH-1];
                wbData_o    <= r_mul_data[MUL_DEPTH-1];
            end else if (r_state == S_DONE) begin
                wbValid_o   <= 1'b1;
                wbPhyDest_o <= r_div_tag;
                wbAlID_o    <= r_div_al;
                wbData_o    <= w_div_res;
            end
        end
    end
endmodule

// File: tb/tb_execute_lane_mc.sv
// Scoreboard bench for execute_lane_mc: the issue task predicts ready_o and pushes expected writebacks
// from an arithmetic reference model; an independent monitor matches every writeback against the queue.
module tb_execute_lane_mc;
    localparam int DW  = 32;
    localparam int PW  = 7;
    localparam int AW  = 7;
    localparam int NB  = 4;
    localparam int MD  = 3;
    localparam int DIV_LAT = DW + 2;

    logic               clk = 1'b0;
    logic               reset;
    logic               recoverFlag_i, valid_i, isSimple_i;
    logic               ready_o, wbValid_o, divBusy_o;
    logic [2:0]         op_i;
    logic [PW-1:0]      phySrc1_i, phySrc2_i, phyDest_i, wbPhyDest_o;
    logic [DW-1:0]      src1Data_i, src2Data_i, wbData_o;
    logic [AW-1:0]      alID_i, wbAlID_o;
    logic [NB-1:0]      bypValid_i;
    logic [NB*PW-1:0]   bypTag_i;
    logic [NB*DW-1:0]   bypData_i;

    execute_lane_mc #(.DATA_W(DW), .PREG_W(PW), .AL_W(AW), .NUM_BYPASS(NB), .MUL_DEPTH(MD)) dut (
        .clk(clk), .reset(reset), .recoverFlag_i(recoverFlag_i), .valid_i(valid_i), .ready_o(ready_o),
        .isSimple_i(isSimple_i), .op_i(op_i), .phySrc1_i(phySrc1_i), .phySrc2_i(phySrc2_i),
        .src1Data_i(src1Data_i), .src2Data_i(src2Data_i), .phyDest_i(phyDest_i), .alID_i(alID_i),
        .bypValid_i(bypValid_i), .bypTag_i(bypTag_i), .bypData_i(bypData_i), .wbValid_o(wbValid_o),
        .wbPhyDest_o(wbPhyDest_o), .wbAlID_o(wbAlID_o), .wbData_o(wbData_o), .divBusy_o(divBusy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            due;
        logic [PW-1:0] tag;
        logic [AW-1:0] al;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   div_from = 0;
    int   div_until = -1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int lat(input bit simp, input bit [2:0] op);
        if (simp) return 1;
        if (op <= 3'd1) return MD;
        if (op <= 3'd5) return DIV_LAT;
        return 1;
    endfunction

    function automatic logic [DW-1:0] fwd(input logic [PW-1:0] tag, input logic [DW-1:0] rf);
        for (int i = 0; i < NB; i++)
            if (bypValid_i[i] && bypTag_i[i*PW +: PW] == tag) return bypData_i[i*DW +: DW];
        return rf;
    endfunction

    function automatic logic [DW-1:0] model(input bit simp, input bit [2:0] op,
                                            input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [63:0] p;
        int sa, sb_;
        bit sgn, want_rem;
        logic [DW-1:0] q, r;
        sa = a;
        sb_ = b;
        if (simp) begin
            case (op)
                3'd0: return a + b;
                3'd1: return a - b;
                3'd2: return a & b;
                3'd3: return a | b;
                3'd4: return a ^ b;
                3'd5: return (sa < sb_) ? 32'd1 : 32'd0;
                3'd6: return (a < b) ? 32'd1 : 32'd0;
                default: return a << b[4:0];
            endcase
        end
        p = 64'(a) * 64'(b);
        if (op == 3'd0) return p[31:0];
        if (op == 3'd1) return p[63:32];
        if (op >= 3'd6) return '0;
        sgn = (op == 3'd2) || (op == 3'd4);
        want_rem = (op >= 3'd4);
        if (b == 0) begin
            q = '1; r = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a; r = '0;
        end else if (sgn) begin
            q = 32'(sa / sb_); r = 32'(sa % sb_);
        end else begin
            q = a / b; r = a % b;
        end
        return want_rem ? r : q;
    endfunction

    function automatic bit booked(input int due);
        foreach (sb[i]) if (sb[i].due == due) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit div_busy();
        return (cyc >= div_from) && (cyc <= div_until);
    endfunction

    // Called just after a rising edge; returns just after the next rising edge.
    task automatic issue(input bit v, input bit simp, input bit [2:0] op, input logic [DW-1:0] d1,
                         input logic [DW-1:0] d2, input logic [PW-1:0] ps1, input logic [PW-1:0] ps2,
                         input bit rec);
        int   L;
        bit   isdiv, exp_rdy;
        exp_t e;
        valid_i = v; isSimple_i = simp; op_i = op;
        src1Data_i = d1; src2Data_i = d2; phySrc1_i = ps1; phySrc2_i = ps2;
        recoverFlag_i = rec;
        phyDest_i = PW'($urandom); alID_i = AW'($urandom);
        L = lat(simp, op);
        isdiv = !simp && (op >= 3'd2) && (op <= 3'd5);
        @(negedge clk);
        exp_rdy = !rec && !booked(cyc + L) && !(isdiv && div_busy());
        chk("ready", 32'(ready_o), 32'(exp_rdy));
        chk("divbusy", 32'(divBusy_o), 32'(div_busy()));
        if (rec) begin
            for (int i = sb.size()-1; i >= 0; i--) if (sb[i].due > cyc) sb.delete(i);
            if (div_until > cyc) div_until = cyc;
        end else if (v && exp_rdy) begin
            e.due = cyc + L; e.tag = phyDest_i; e.al = alID_i;
            e.data = model(simp, op, fwd(ps1, d1), fwd(ps2, d2));
            sb.push_back(e);
            if (isdiv) begin
                div_from = cyc + 1;
                div_until = cyc + L - 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) issue(1'b0, 1'b1, 3'd0, '0, '0, '0, '0, 1'b0);
    endtask

    task automatic wait_div();
        for (int k = 0; k < DIV_LAT + 4 && div_busy(); k++) idle(1);
    endtask

    task automatic set_byp(input int ch, input bit v, input logic [PW-1:0] t, input logic [DW-1:0] d);
        bypValid_i[ch] = v;
        bypTag_i[ch*PW +: PW] = t;
        bypData_i[ch*DW +: DW] = d;
    endtask

    function automatic logic [DW-1:0] pick_val();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 9));
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clk) begin
        int idx;
        if (wbValid_o === 1'b1) begin
            idx = -1;
            foreach (sb[i]) if (sb[i].due == cyc) idx = i;
            if (idx < 0) begin
                checks++; errors++;
                $display("FAIL wb_unexpected: got tag %h data %h, required no writeback (cycle %0d)",
                         wbPhyDest_o, wbData_o, cyc);
            end else begin
                chk("wb_data", wbData_o, sb[idx].data);
                chk("wb_tag", 32'(wbPhyDest_o), 32'(sb[idx].tag));
                chk("wb_alid", 32'(wbAlID_o), 32'(sb[idx].al));
                sb.delete(idx);
            end
        end
        for (int i = sb.size()-1; i >= 0; i--) begin
            if (sb[i].due <= cyc) begin
                checks++; errors++;
                $display("FAIL wb_missing: got no writeback, required data %h tag %h (cycle %0d)",
                         sb[i].data, sb[i].tag, cyc);
                sb.delete(i);
            end
        end
    end

    initial begin
        reset = 1'b0; recoverFlag_i = 1'b0;
        valid_i = 1'b1; isSimple_i = 1'b1; op_i = 3'd0;
        phySrc1_i = '0; phySrc2_i = '0; src1Data_i = 32'd5; src2Data_i = 32'd7;
        phyDest_i = '0; alID_i = '0;
        bypValid_i = '0; bypTag_i = '0; bypData_i = '0;

        // T1: reset
        repeat (2) begin
            @(negedge clk);
            chk("rst_ready", 32'(ready_o), 32'd0);
            chk("rst_wbvalid", 32'(wbValid_o), 32'd0);
            chk("rst_wbdata", wbData_o, 32'd0);
            chk("rst_divbusy", 32'(divBusy_o), 32'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        issue(1'b1, 1'b1, 3'd0, 32'd5, 32'd7, 7'd1, 7'd2, 1'b0);
        idle(2);

        // T2: lowest matching bypass channel wins
        set_byp(0, 1'b1, 7'd9, 32'h1111);
        set_byp(1, 1'b1, 7'd3, 32'hA);
        set_byp(2, 1'b0, 7'd3, 32'h2222);
        set_byp(3, 1'b1, 7'd3, 32'hB);
        issue(1'b1, 1'b1, 3'd1, 32'h55, 32'h1, 7'd3, 7'd4, 1'b0);
        bypValid_i = '0;
        idle(2);

        // T3: simple op blocked by the slot a MUL already holds
        issue(1'b1, 1'b0, 3'd0, 32'd1234, 32'd5678, 7'd1, 7'd2, 1'b0);
        idle(MD - 2);
        issue(1'b1, 1'b1, 3'd4, 32'hF0F0, 32'h0FF0, 7'd1, 7'd2, 1'b0);
        issue(1'b1, 1'b1, 3'd4, 32'hF0F0, 32'h0FF0, 7'd1, 7'd2, 1'b0);
        issue(1'b1, 1'b0, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 7'd1, 7'd2, 1'b0);
        idle(MD + 1);

        // T4: divider corner cases
        issue(1'b1, 1'b0, 3'd2, 32'hFFFF_FFF9, 32'd2, 7'd1, 7'd2, 1'b0);
        wait_div();
        issue(1'b1, 1'b0, 3'd4, 32'hFFFF_FFF9, 32'd2, 7'd1, 7'd2, 1'b0);
        wait_div();
        issue(1'b1, 1'b0, 3'd3, 32'd1000, 32'd0, 7'd1, 7'd2, 1'b0);
        wait_div();
        issue(1'b1, 1'b0, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 7'd1, 7'd2, 1'b0);
        wait_div();
        issue(1'b1, 1'b0, 3'd5, 32'hFFFF_FFF9, 32'd0, 7'd1, 7'd2, 1'b0);
        wait_div();

        // T5: second divide refused while busy, ALU op proceeds
        issue(1'b1, 1'b0, 3'd3, 32'd100, 32'd7, 7'd1, 7'd2, 1'b0);
        issue(1'b1, 1'b0, 3'd2, 32'd50, 32'd3, 7'd1, 7'd2, 1'b0);
        issue(1'b1, 1'b1, 3'd0, 32'd40, 32'd2, 7'd1, 7'd2, 1'b0);
        wait_div();
        idle(2);

        // T6: recovery with a divide and two multiplies in flight
        issue(1'b1, 1'b0, 3'd2, 32'd999, 32'd9, 7'd1, 7'd2, 1'b0);
        idle(5);
        issue(1'b1, 1'b0, 3'd0, 32'd3, 32'd4, 7'd1, 7'd2, 1'b0);
        issue(1'b1, 1'b0, 3'd1, 32'hDEAD_BEEF, 32'hCAFE_F00D, 7'd1, 7'd2, 1'b0);
        issue(1'b1, 1'b1, 3'd0, 32'd1, 32'd1, 7'd1, 7'd2, 1'b1);
        issue(1'b1, 1'b1, 3'd0, 32'd21, 32'd21, 7'd1, 7'd2, 1'b0);
        idle(DIV_LAT + 2);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            for (int ch = 0; ch < NB; ch++)
                set_byp(ch, 1'($urandom), PW'($urandom_range(0, 7)), pick_val());
            issue($urandom_range(0, 3) != 0, 1'($urandom), 3'($urandom), pick_val(), pick_val(),
                  PW'($urandom_range(0, 7)), PW'($urandom_range(0, 7)), $urandom_range(0, 49) == 0);
        end
        bypValid_i = '0;

        for (int k = 0; k < DIV_LAT + 8 && sb.size() != 0; k++) idle(1);
        chk("drain_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
